// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction fetch with IF/ID register,
// one-entry skid buffer and redirect/discard handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [6:0]  op_d,
  output logic [2:0]  funct3_d,
  output logic        funct7b5_d
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    STALL   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_run;
  logic [31:0] r_pc_f;
  logic [31:0] r_stale;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc4_d;
  logic        r_valid_d;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  logic        w_resp;
  logic        w_acc;
  logic [31:0] w_tgt;
  logic [31:0] w_pc4;

  // r_run keeps the request low until the first edge after reset.
  assign imem_req  = r_run && (r_state != STALL);
  assign imem_addr = (r_state == DISCARD) ? r_stale : r_pc_f;
  assign w_resp    = imem_valid && imem_req;
  assign w_acc     = !stall_d || !r_valid_d;
  assign w_tgt     = pc_target_e & ~32'd3;
  assign w_pc4     = r_pc_f + 32'd4;

  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc4_d;
  assign valid_d    = r_valid_d;
  assign op_d       = r_instr_d[6:0];
  assign funct3_d   = r_instr_d[14:12];
  assign funct7b5_d = r_instr_d[30];

  // Fetch FSM, PC, skid buffer and IF/ID register update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_run        <= 1'b0;
      r_pc_f       <= RESET_PC;
      r_stale      <= 32'd0;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc4_d      <= 32'd0;
      r_valid_d    <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= 32'd0;
    end else begin
      r_run <= 1'b1;
      if (pc_src_e) begin
        r_valid_d    <= 1'b0;
        r_instr_d    <= NOP_INSTR;
        r_skid_instr <= NOP_INSTR;
        r_skid_pc    <= 32'd0;
        r_pc_f       <= w_tgt;
        unique case (r_state)
          FETCH: begin
            if (imem_req && !imem_valid) begin
              r_state <= DISCARD;
              r_stale <= r_pc_f;
            end else begin
              r_state <= FETCH;
            end
          end
          DISCARD: r_state <= w_resp ? FETCH : DISCARD;
          default: r_state <= FETCH;
        endcase
      end else begin
        unique case (r_state)
          FETCH: begin
            if (w_resp) begin
              r_pc_f <= w_pc4;
              if (w_acc) begin
                r_instr_d <= imem_rdata;
                r_pc_d    <= r_pc_f;
                r_pc4_d   <= w_pc4;
                r_valid_d <= 1'b1;
              end else begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_pc_f;
                r_state      <= STALL;
              end
            end else if (w_acc) begin
              r_valid_d <= 1'b0;
              r_instr_d <= NOP_INSTR;
            end
          end
          DISCARD: begin
            if (w_resp) begin
              r_state <= FETCH;
            end
          end
          STALL: begin
            if (!stall_d) begin
              r_instr_d <= r_skid_instr;
              r_pc_d    <= r_skid_pc;
              r_pc4_d   <= r_skid_pc + 32'd4;
              r_valid_d <= 1'b1;
              r_state   <= FETCH;
            end
          end
          default: r_state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized
// stream check of fetch_stage against an in-order PC model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [6:0]  op_d;
  logic [2:0]  funct3_d;
  logic        funct7b5_d;
  logic        mem_en;

  int n_chk;
  int n_fail;

  fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .stall_d    (stall_d),
    .pc_src_e   (pc_src_e),
    .pc_target_e(pc_target_e),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d),
    .op_d       (op_d),
    .funct3_d   (funct3_d),
    .funct7b5_d (funct7b5_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // zero-wait memory: answers in the cycle of the request
  assign imem_rdata = tag(imem_addr);
  assign imem_valid = mem_en && imem_req;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        stl;
    logic        src;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pcd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t row(
    input logic rst, input logic en, input logic stl,
    input logic src, input logic [31:0] tgt,
    input logic req, input logic [31:0] addr,
    input logic vld, input logic [31:0] pcd);
    vec_t v;
    v.rst = rst; v.en = en; v.stl = stl; v.src = src;
    v.tgt = tgt; v.req = req; v.addr = addr;
    v.vld = vld; v.pcd = pcd;
    return v;
  endfunction

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] ei;
    logic [31:0] tgt;
    logic        p_vld, p_stl, p_src, p_req, p_val;
    logic [31:0] p_ins, p_pcd, p_pc4, p_addr, p_tgt;
    int          consumed;

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    mem_en = 1'b0;
    stall_d = 1'b0;
    pc_src_e = 1'b0;
    pc_target_e = 32'd0;

    //       rst en stl src tgt           req addr          vld pcd
    vq.push_back(row(0,1,0,0,32'h0,        0,32'h0,        0,32'h0));
    vq.push_back(row(0,1,0,0,32'h0,        0,32'h0,        0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h0,        0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h4,        1,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h8,        1,32'h4));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'hC,        1,32'h8));
    vq.push_back(row(1,1,1,0,32'h0,        0,32'h10,       1,32'h8));
    vq.push_back(row(1,1,1,0,32'h0,        0,32'h10,       1,32'h8));
    vq.push_back(row(1,1,1,0,32'h0,        0,32'h10,       1,32'h8));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h10,       1,32'hC));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h14,       1,32'h10));
    vq.push_back(row(1,0,0,0,32'h0,        1,32'h14,       0,32'h0));
    vq.push_back(row(1,0,0,0,32'h0,        1,32'h14,       0,32'h0));
    vq.push_back(row(1,0,0,0,32'h0,        1,32'h14,       0,32'h0));
    vq.push_back(row(1,0,0,0,32'h0,        1,32'h14,       0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h18,       1,32'h14));
    vq.push_back(row(1,0,0,1,32'h102,      1,32'h18,       0,32'h0));
    vq.push_back(row(1,0,0,0,32'h0,        1,32'h18,       0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h100,      0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h104,      1,32'h100));
    vq.push_back(row(1,1,1,1,32'h200,      1,32'h200,      0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h204,      1,32'h200));
    vq.push_back(row(1,1,1,0,32'h0,        0,32'h208,      1,32'h200));
    vq.push_back(row(0,1,1,0,32'h0,        0,32'h0,        0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h0,        0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h4,        1,32'h0));
    vq.push_back(row(1,1,1,0,32'h0,        0,32'h8,        1,32'h0));
    vq.push_back(row(1,1,1,1,32'hFFFFFFFC, 1,32'hFFFFFFFC, 0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h0,        1,32'hFFFFFFFC));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h4,        1,32'h0));
    vq.push_back(row(1,0,0,1,32'h40,       1,32'h4,        0,32'h0));
    vq.push_back(row(1,0,0,1,32'h80,       1,32'h4,        0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h80,       0,32'h0));
    vq.push_back(row(1,1,0,0,32'h0,        1,32'h84,       1,32'h80));

    foreach (vq[i]) begin
      rst_n = vq[i].rst;
      mem_en = vq[i].en;
      stall_d = vq[i].stl;
      pc_src_e = vq[i].src;
      pc_target_e = vq[i].tgt;
      @(posedge clk);
      #1;
      ei = vq[i].vld ? tag(vq[i].pcd) : NOP;
      chk($sformatf("v%0d req", i), 32'(imem_req), 32'(vq[i].req));
      chk($sformatf("v%0d addr", i), imem_addr, vq[i].addr);
      chk($sformatf("v%0d valid_d", i), 32'(valid_d), 32'(vq[i].vld));
      chk($sformatf("v%0d instr_d", i), instr_d, ei);
      chk($sformatf("v%0d op_d", i), 32'(op_d), 32'(ei[6:0]));
      if (vq[i].vld) begin
        chk($sformatf("v%0d pc_d", i), pc_d, vq[i].pcd);
        chk($sformatf("v%0d pc_plus4_d", i), pc_plus4_d,
            vq[i].pcd + 32'd4);
        chk($sformatf("v%0d funct3", i), 32'(funct3_d),
            32'(ei[14:12]));
        chk($sformatf("v%0d funct7b5", i), 32'(funct7b5_d),
            32'(ei[30]));
      end
    end

    // randomized phase: fresh reset, then in-order stream model
    rst_n = 1'b0;
    mem_en = 1'b1;
    stall_d = 1'b0;
    pc_src_e = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = 32'h0;
    consumed = 0;

    for (int c = 0; c < 3000; c++) begin
      mem_en = ($urandom_range(0, 9) < 7);
      stall_d = ($urandom_range(0, 9) < 3);
      pc_src_e = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0)
        tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      pc_target_e = tgt;
      @(negedge clk);
      p_vld = valid_d; p_stl = stall_d; p_src = pc_src_e;
      p_req = imem_req; p_val = imem_valid; p_addr = imem_addr;
      p_ins = instr_d; p_pcd = pc_d; p_pc4 = pc_plus4_d;
      p_tgt = pc_target_e;
      @(posedge clk);
      #1;
      if (p_src) begin
        chk("flush valid_d", 32'(valid_d), 32'd0);
        exp_pc = {p_tgt[31:2], 2'b00};
      end else if (p_vld && p_stl) begin
        chk("hold instr_d", instr_d, p_ins);
        chk("hold pc_d", pc_d, p_pcd);
        chk("hold pc_plus4_d", pc_plus4_d, p_pc4);
        chk("hold valid_d", 32'(valid_d), 32'd1);
      end else if (p_vld) begin
        chk("stream pc_d", p_pcd, exp_pc);
        chk("stream instr_d", p_ins, tag(exp_pc));
        chk("stream pc_plus4_d", p_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (p_req && !p_val)
        chk("addr stable", imem_addr, p_addr);
      if (!valid_d)
        chk("bubble nop", instr_d, NOP);
      chk("addr aligned", 32'(imem_addr[1:0]), 32'd0);
    end
    chk("liveness", 32'(consumed >= 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, value loaded into instr_d on reset and flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  instruction memory request.
REQ-006 imem_addr  output  32  fetch address, word aligned.
REQ-007 imem_rdata  input  32  instruction returned by memory.
REQ-008 imem_valid  input  1  imem_rdata valid for the outstanding request.
REQ-009 stall_d  input  1  decode stage cannot accept a new instruction.
REQ-010 pc_src_e  input  1  taken branch/jump redirect from execute.
REQ-011 pc_target_e  input  32  redirect target.
REQ-012 instr_d, pc_d, pc_plus4_d  output  32 each  IF/ID register contents.
REQ-013 valid_d  output  1  IF/ID register holds a live instruction.
REQ-014 op_d  output  7  instr_d[6:0], combinational, feeds control unit op.
REQ-015 funct3_d  output  3  instr_d[14:12], combinational.
REQ-016 funct7b5_d  output  1  instr_d[30], combinational, feeds control unit funct7.

Function
REQ-017 FSM states FETCH, DISCARD, STALL shall be implemented; one outstanding memory request maximum.
REQ-018 imem_addr shall equal pc_f in FETCH and the stale address in DISCARD; held stable while imem_req=1 and imem_valid=0.
REQ-019 imem_req shall be 1 in FETCH and DISCARD, 0 in STALL.
REQ-020 "Decode accepts" shall mean stall_d=0 or valid_d=0.
REQ-021 FETCH, imem_valid=1, pc_src_e=0, decode accepts: instr_d<=imem_rdata, pc_d<=pc_f, pc_plus4_d<=pc_f+4, valid_d<=1, pc_f<=pc_f+4, stay FETCH.
REQ-022 FETCH, imem_valid=1, pc_src_e=0, decode not accepting: imem_rdata and pc_f captured into a skid register, pc_f<=pc_f+4, go STALL; IF/ID held.
REQ-023 FETCH, imem_valid=0, decode accepts: valid_d<=0 (bubble), instr_d<=NOP_INSTR.
REQ-024 STALL, stall_d=0, pc_src_e=0: skid contents move to IF/ID with valid_d<=1, go FETCH.
REQ-025 pc_src_e=1 in any state shall take priority over stall_d and imem_valid: valid_d<=0, instr_d<=NOP_INSTR, skid discarded, pc_f<={pc_target_e[31:2],2'b00}.
REQ-026 Redirect in FETCH with imem_valid=0: go DISCARD; first subsequent imem_valid response dropped, then FETCH at new pc_f.
REQ-027 Redirect in FETCH with imem_valid=1 or in STALL: response/skid dropped, go FETCH next cycle.
REQ-028 Redirect in DISCARD: update pc_f only, remain DISCARD until imem_valid.
REQ-029 stall_d with valid_d=1 and no redirect shall hold instr_d, pc_d, pc_plus4_d, valid_d unchanged.
REQ-030 pc_f and pc_plus4_d arithmetic shall be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-031 No instruction shall be dropped or duplicated absent a redirect.

Reset
REQ-032 rst_n=0 at a clock edge: state<=FETCH, pc_f<=RESET_PC, valid_d<=0, instr_d<=NOP_INSTR, pc_d<=0, pc_plus4_d<=0, skid cleared.
REQ-033 imem_req shall be 0 while rst_n=0, registered-1 from the first edge after release.
REQ-034 Reset mid-request or in DISCARD/STALL shall abandon the pending response; no response arriving during reset shall be captured.

Verification
REQ-035 Reset release, imem_valid=1 every cycle, rdata=addr-tagged -> imem_addr 0,4,8; valid_d=1 from cycle 2, pc_d 0,4,8 consecutive.
REQ-036 stall_d=1 for 3 cycles with valid_d=1 -> IF/ID frozen, imem_req=0 in STALL, after release next two instructions delivered in order, none lost.
REQ-037 pc_src_e=1, pc_target_e=32'h0000_0102 while imem_valid=0 -> DISCARD, late response dropped, next imem_addr=32'h0000_0100, valid_d=0 for flush cycle.
REQ-038 pc_src_e=1 and stall_d=1 same cycle -> valid_d=0, instr_d=32'h0000_0013 next cycle.
REQ-039 imem_valid held 0 for 4 cycles -> imem_addr stable, valid_d=0 bubbles, op_d=7'h13.
REQ-040 rst_n=0 asserted in STALL -> next cycle valid_d=0, imem_req=0; after release fetch restarts at RESET_PC.
